// File: rtl/inst_fetch_unit_pkg.sv
// Shared fetch-stage definitions: NOP encoding, reset PC default, RV64 opcodes
// and the fetch FSM state type.
package inst_fetch_unit_pkg;

    localparam logic [31:0] RV_NOP       = 32'h0000_0013;
    localparam logic [63:0] RESET_PC_DEF = 64'h0000_0000_8000_0000;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/inst_fetch_unit_fetch_fifo.sv
// Small power-of-two FIFO with registered storage; flush wins over push/pop.
module fetch_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset; the empty flag masks stale contents.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch stage: one outstanding imem read, credit-limited instruction buffer, redirect flush.
// Define IFU_TRACE_EN to print every buffered instruction and redirect target in simulation.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int               XLEN       = 64,
    parameter logic [XLEN-1:0]  RESET_PC   = RESET_PC_DEF[XLEN-1:0],
    parameter int               FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [XLEN-1:0]  imem_req_addr,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_data,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             id_valid,
    input  logic             id_ready,
    output logic [31:0]      id_inst,
    output logic [XLEN-1:0]  id_pc,
    output logic [6:0]       id_op_code
);
    fetch_state_t                  state;
    logic [XLEN-1:0]               pc_q;
    logic [XLEN-1:0]               req_pc;
    logic                          outstanding;
    logic                          credit_ok;
    logic                          accept;
    logic                          push;
    logic                          pop;
    logic [XLEN+31:0]              fifo_head;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          unused_redir_lsb;

    assign unused_redir_lsb = ^redirect_pc[1:0];

    // Buffered entries plus the in-flight read never exceed the buffer size,
    // so a response always has a slot waiting for it.
    assign outstanding    = (state != ST_REQ);
    assign credit_ok      = (32'(fifo_count) + 32'(outstanding)) < 32'(FIFO_DEPTH);
    assign imem_req_valid = !rst && (state == ST_REQ) && credit_ok && !redirect_valid;
    assign imem_req_addr  = pc_q;
    assign accept         = imem_req_valid && imem_req_ready;

    assign push = (state == ST_WAIT) && imem_rsp_valid && !redirect_valid && !fifo_full;
    assign pop  = id_valid && id_ready && !redirect_valid;

    fetch_fifo #(
        .WIDTH (XLEN + 32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data ({req_pc, imem_rsp_data}),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign id_valid   = !fifo_empty;
    assign id_inst    = fifo_empty ? RV_NOP : fifo_head[31:0];
    assign id_pc      = fifo_empty ? '0 : fifo_head[XLEN+31:32];
    assign id_op_code = id_inst[6:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_REQ;
            pc_q   <= RESET_PC;
            req_pc <= '0;
        end else if (redirect_valid) begin
            pc_q <= {redirect_pc[XLEN-1:2], 2'b00};
            // A read still in flight must be swallowed before fetching again.
            state <= (outstanding && !imem_rsp_valid) ? ST_DROP : ST_REQ;
        end else begin
            case (state)
                ST_REQ: begin
                    if (accept) begin
                        req_pc <= pc_q;
                        pc_q   <= pc_q + XLEN'(4);
                        state  <= ST_WAIT;
                    end
                end
                ST_WAIT: if (imem_rsp_valid) state <= ST_REQ;
                ST_DROP: if (imem_rsp_valid) state <= ST_REQ;
                default: state <= ST_REQ;
            endcase
        end
    end

`ifdef IFU_TRACE_EN
    always_ff @(posedge clk) begin
        if (!rst && push)           $display("IFU pc=%h inst=%h", req_pc, imem_rsp_data);
        if (!rst && redirect_valid) $display("IFU redirect=%h", redirect_pc);
    end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: random imem/decode traffic checked against a PC-stream model.
module tb_inst_fetch_unit;
    import inst_fetch_unit_pkg::*;

    localparam logic [63:0] RPC = 64'h0000_0000_8000_0000;

    logic        clk, rst;
    logic        imem_req_valid, imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        id_valid, id_ready;
    logic [31:0] id_inst;
    logic [63:0] id_pc;
    logic [6:0]  id_op_code;

    inst_fetch_unit #(.XLEN(64), .RESET_PC(RPC), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst),
        .id_pc(id_pc), .id_op_code(id_op_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_bad = 0, n_pops = 0;
    int dmin = 1, dmax = 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Instruction memory contents: a fixed function of the word address.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        logic [6:0] opc;
        case (a[4:2])
            3'd0: opc = OPC_LOAD;
            3'd1: opc = OPC_STORE;
            3'd2: opc = OPC_OP_IMM;
            3'd3: opc = OPC_OP;
            3'd4: opc = OPC_AUIPC;
            3'd5: opc = 7'h6F;
            3'd6: opc = 7'h63;
            default: opc = 7'h67;
        endcase
        return {a[26:2] ^ 25'h0AB_CDEF, opc};
    endfunction

    // Memory responder: one response per accepted request, dmin..dmax cycles later.
    logic        pend;
    int          pend_due;
    logic [31:0] pend_data;
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        pend = 1'b0;
        pend_due = 0;
        pend_data = '0;
        forever begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) begin
                pend      = 1'b1;
                pend_due  = cyc + int'($urandom_range(dmax, dmin));
                pend_data = mem_word(imem_req_addr);
            end
            if (pend && pend_due == cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = pend_data;
                pend = 1'b0;
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = $urandom;
            end
        end
    end

    // Reference model: the delivered stream is the sequential PC run starting at
    // the reset PC or the last aligned redirect target.
    logic [63:0] model_pc;
    logic [63:0] exp_q[$];
    logic        prev_stall;
    logic [63:0] prev_addr;
    initial begin
        logic [63:0] e;
        logic [31:0] ei;
        model_pc   = RPC;
        prev_stall = 1'b0;
        prev_addr  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                model_pc   = RPC;
                prev_stall = 1'b0;
            end else begin
                if (id_valid && id_ready && !redirect_valid) begin
                    if (exp_q.size() == 0) begin
                        exp_q.push_back(model_pc);
                        model_pc = model_pc + 64'd4;
                    end
                    e  = exp_q.pop_front();
                    ei = mem_word(e);
                    n_pops++;
                    chk("pop_pc", id_pc, e);
                    chk("pop_inst", {32'h0, id_inst}, {32'h0, ei});
                    chk("pop_opcode", {57'h0, id_op_code}, {57'h0, ei[6:0]});
                end
                if (!id_valid) begin
                    chk("empty_inst", {32'h0, id_inst}, {32'h0, RV_NOP});
                    chk("empty_pc", id_pc, 64'h0);
                end
                if (prev_stall && !redirect_valid) begin
                    chk("stall_valid", {63'h0, imem_req_valid}, 64'h1);
                    chk("stall_addr", imem_req_addr, prev_addr);
                end
                if (redirect_valid) begin
                    chk("redirect_retract", {63'h0, imem_req_valid}, 64'h0);
                    exp_q.delete();
                    model_pc = {redirect_pc[63:2], 2'b00};
                end
                prev_stall = imem_req_valid && !imem_req_ready;
                prev_addr  = imem_req_addr;
            end
        end
    end

    // kind: 0 accept, 1 accept with buffered entry, 2 id_valid, 3 req_valid
    task automatic wait_cond(input int kind, input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            @(negedge clk);
            case (kind)
                0: hit = imem_req_valid && imem_req_ready;
                1: hit = imem_req_valid && imem_req_ready && id_valid;
                2: hit = id_valid;
                default: hit = imem_req_valid;
            endcase
        end
        if (!hit) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout_%s: got no event expected event within 60 cycles", name);
        end
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] acc[$];
        rst = 1'b1;
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        id_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_req_valid", {63'h0, imem_req_valid}, 64'h0);
        chk("reset_id_valid", {63'h0, id_valid}, 64'h0);
        chk("reset_id_inst", {32'h0, id_inst}, {32'h0, RV_NOP});
        chk("reset_id_pc", id_pc, 64'h0);

        // Latency: accept in cycle 0, response in 1, id_valid in 2.
        drive_edge();
        rst = 1'b0; imem_req_ready = 1'b1; id_ready = 1'b1; dmin = 1; dmax = 1;
        @(negedge clk);
        chk("c0_req_valid", {63'h0, imem_req_valid}, 64'h1);
        chk("c0_addr", imem_req_addr, RPC);
        @(negedge clk);
        chk("c1_req_valid", {63'h0, imem_req_valid}, 64'h0);
        chk("c1_id_valid", {63'h0, id_valid}, 64'h0);
        @(negedge clk);
        chk("c2_id_valid", {63'h0, id_valid}, 64'h1);
        chk("c2_id_pc", id_pc, RPC);
        chk("c2_addr", imem_req_addr, RPC + 64'd4);
        @(negedge clk);
        chk("c3_id_valid", {63'h0, id_valid}, 64'h0);
        @(negedge clk);
        chk("c4_id_pc", id_pc, RPC + 64'd4);
        chk("c4_addr", imem_req_addr, RPC + 64'd8);

        // Decode backpressure: buffer fills to two, then requests stop.
        drive_edge();
        id_ready = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("bp_req_valid", {63'h0, imem_req_valid}, 64'h0);
        a = imem_req_addr;
        @(negedge clk);
        chk("bp_addr_held", imem_req_addr, a);
        drive_edge();
        id_ready = 1'b1;
        @(negedge clk);
        chk("bp_drain0", {63'h0, id_valid}, 64'h1);
        @(negedge clk);
        chk("bp_drain1", {63'h0, id_valid}, 64'h1);
        @(negedge clk);
        chk("bp_drain2", {63'h0, id_valid}, 64'h0);

        // Memory backpressure: request and address hold.
        drive_edge();
        imem_req_ready = 1'b0;
        wait_cond(3, "stall_req");
        a = imem_req_addr;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("mstall_valid", {63'h0, imem_req_valid}, 64'h1);
            chk("mstall_addr", imem_req_addr, a);
        end
        drive_edge();
        imem_req_ready = 1'b1;
        @(negedge clk);
        chk("mstall_accept_addr", imem_req_addr, a);

        // Redirect while waiting; response lands three cycles after accept.
        drive_edge();
        id_ready = 1'b0; dmin = 3; dmax = 3;
        wait_cond(1, "redir_wait");
        drive_edge();
        redirect_valid = 1'b1; redirect_pc = RPC + 64'h100;
        drive_edge();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("redir_flushed", {63'h0, id_valid}, 64'h0);
        drive_edge();
        id_ready = 1'b1;
        wait_cond(2, "redir_deliver");
        chk("redir_first_pc", id_pc, RPC + 64'h100);

        // Redirect, pop and response all in one cycle.
        drive_edge();
        id_ready = 1'b0; dmin = 1; dmax = 1;
        wait_cond(1, "collide_setup");
        drive_edge();
        id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = RPC + 64'h102;
        @(negedge clk);
        chk("collide_rsp", {63'h0, imem_rsp_valid}, 64'h1);
        chk("collide_id_valid", {63'h0, id_valid}, 64'h1);
        drive_edge();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("collide_flushed", {63'h0, id_valid}, 64'h0);
        wait_cond(2, "collide_deliver");
        chk("collide_first_pc", id_pc, RPC + 64'h100);

        // Address wrap at the top of the address space.
        drive_edge();
        redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        drive_edge();
        redirect_valid = 1'b0;
        for (int i = 0; i < 40 && acc.size() < 2; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) acc.push_back(imem_req_addr);
        end
        if (acc.size() < 2) begin
            n_cmp++; n_bad++;
            $display("FAIL wrap_accepts: got %0d expected 2", acc.size());
        end else begin
            chk("wrap_addr0", acc[0], 64'hFFFF_FFFF_FFFF_FFFC);
            chk("wrap_addr1", acc[1], 64'h0);
        end

        // Reset while a read is in flight; its late response must be ignored.
        drive_edge();
        id_ready = 1'b0; dmin = 3; dmax = 3;
        wait_cond(1, "rst_wait");
        drive_edge();
        rst = 1'b1;
        #1;
        chk("rst_mid_id_valid", {63'h0, id_valid}, 64'h0);
        chk("rst_mid_req_valid", {63'h0, imem_req_valid}, 64'h0);
        drive_edge();
        rst = 1'b0; imem_req_ready = 1'b0;
        repeat (4) drive_edge();
        chk("rst_restart_valid", {63'h0, imem_req_valid}, 64'h1);
        chk("rst_restart_addr", imem_req_addr, RPC);
        imem_req_ready = 1'b1; id_ready = 1'b1; dmin = 1; dmax = 3;
        wait_cond(2, "rst_deliver");
        chk("rst_first_pc", id_pc, RPC);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            drive_edge();
            imem_req_ready = ($urandom_range(0, 3) != 0);
            id_ready       = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 40) == 0);
            case ($urandom_range(0, 2))
                0: redirect_pc = {$urandom, $urandom};
                1: redirect_pc = RPC + 64'($urandom_range(0, 255));
                default: redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
            endcase
        end
        drive_edge();
        redirect_valid = 1'b0; imem_req_ready = 1'b1; id_ready = 1'b1;
        repeat (20) @(posedge clk);
        chk("progress", {63'h0, n_pops > 300}, 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit");
    end

endmodule
